// File: rtl/fsm_symbol_tx.sv
// Word-to-symbol serialiser feeding the two-input sequence detector.
// Each 8-bit word leaves as four 2-bit symbols on {X1,X2}, MSB pair first.
module fsm_symbol_tx #(
    parameter int unsigned HOLD_CYCLES = 1,
    parameter logic [1:0]  IDLE_SYM    = 2'b00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       X1,
    output logic       X2,
    output logic       sym_valid,
    output logic       busy,
    output logic       done
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t     state;
    logic [7:0] sreg;
    logic [1:0] sym_cnt;
    logic [7:0] hold_cnt;

    // Handshake and status depend only on state and reset, never on din/din_valid.
    assign din_ready = (state == IDLE) && rst_n;
    assign busy      = (state == SEND) && rst_n;

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values; blocking here would chain updates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            sreg      <= 8'h00;
            sym_cnt   <= 2'd0;
            hold_cnt  <= 8'h00;
            {X1, X2}  <= IDLE_SYM;
            sym_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    {X1, X2}  <= IDLE_SYM;
                    sym_valid <= 1'b0;
                    if (din_valid) begin
                        // First symbol goes straight out; the rest wait in sreg.
                        sreg      <= {din[5:0], 2'b00};
                        {X1, X2}  <= din[7:6];
                        sym_valid <= 1'b1;
                        sym_cnt   <= 2'd0;
                        hold_cnt  <= 8'h00;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end else if (sym_cnt != 2'd3) begin
                        hold_cnt <= 8'h00;
                        sym_cnt  <= sym_cnt + 2'd1;
                        {X1, X2} <= sreg[7:6];
                        sreg     <= {sreg[5:0], 2'b00};
                    end else begin
                        state     <= IDLE;
                        {X1, X2}  <= IDLE_SYM;
                        sym_valid <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_symbol_tx.sv
// Bench for fsm_symbol_tx: four instances with different hold/idle settings,
// directed cycle tables plus randomized words against a timeline model.
module tb_fsm_symbol_tx;

    function automatic int h_of(input int i);
        case (i)
            0:       return 1;
            1:       return 3;
            2:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic logic [1:0] idle_of(input int i);
        return (i == 3) ? 2'b11 : 2'b00;
    endfunction

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] rst_n;
    logic [7:0] din [4];
    logic [3:0] din_valid;
    logic [3:0] din_ready, x1, x2, sym_valid, busy, done;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        fsm_symbol_tx #(
            .HOLD_CYCLES(h_of(g)),
            .IDLE_SYM   (idle_of(g))
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n[g]),
            .din      (din[g]),
            .din_valid(din_valid[g]),
            .din_ready(din_ready[g]),
            .X1       (x1[g]),
            .X2       (x2[g]),
            .sym_valid(sym_valid[g]),
            .busy     (busy[g]),
            .done     (done[g])
        );
    end

    typedef struct {
        logic [1:0] sym;
        logic       sv;
        logic       dn;
        logic       rdy;
        logic       bsy;
    } exp_t;

    exp_t tab [32];
    int   tab_n;
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic logic [5:0] obs(input int i);
        return {x1[i], x2[i], sym_valid[i], done[i], din_ready[i], busy[i]};
    endfunction

    function automatic logic [5:0] pack(input exp_t e);
        return {e.sym, e.sv, e.dn, e.rdy, e.bsy};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic set_row(input int c, input logic [1:0] s, input logic sv,
                           input logic dn, input logic rdy, input logic bsy);
        tab[c] = '{sym: s, sv: sv, dn: dn, rdy: rdy, bsy: bsy};
        if (c > tab_n) tab_n = c;
    endtask

    // Accepts w1 at edge 0, then compares cycles 1..tab_n against the table.
    task automatic apply(input int i, input string name, input logic [7:0] w1,
                         input logic [7:0] w2, input bit b2b, input int pulse_c);
        @(negedge clk);
        check({name, " ready_before"}, 16'(din_ready[i]), 16'd1);
        din[i] = w1;
        din_valid[i] = 1'b1;
        @(posedge clk);
        #1;
        if (b2b) din[i] = w2;
        else     din_valid[i] = 1'b0;
        for (int c = 1; c <= tab_n; c++) begin
            @(negedge clk);
            check($sformatf("%s c%0d", name, c), 16'(obs(i)), 16'(pack(tab[c])));
            if (b2b && c == 4 * h_of(i) + 2) din_valid[i] = 1'b0;
            if (c == pulse_c) begin
                din[i] = 8'h55;
                din_valid[i] = 1'b1;
            end
            if (c == pulse_c + 1) begin
                din_valid[i] = 1'b0;
                din[i] = w1;
            end
        end
        din_valid[i] = 1'b0;
    endtask

    task automatic pulse_reset(input int i);
        @(negedge clk);
        rst_n[i] = 1'b0;
        @(negedge clk);
        rst_n[i] = 1'b1;
    endtask

    // Reference: cycle number since the accept edge decides everything.
    task automatic run_random(input int i, input int n_cyc);
        int         h;
        bit         m_act;
        int         m_t;
        logic [7:0] m_word;
        logic [1:0] sym;
        logic [5:0] exp;
        bit         m_ready;
        bit         acc;
        h = h_of(i);
        m_act = 0;
        m_t = 0;
        m_word = 8'h00;
        pulse_reset(i);
        for (int n = 0; n < n_cyc; n++) begin
            @(negedge clk);
            if (m_act && m_t >= 1 && m_t <= 4 * h) begin
                sym = 2'((m_word >> (6 - 2 * ((m_t - 1) / h))) & 8'h03);
                exp = {sym, 1'b1, 1'b0, 1'b0, 1'b1};
            end else begin
                exp = {idle_of(i), 1'b0, 1'(m_act && m_t == 4 * h + 1), 1'b1, 1'b0};
            end
            check($sformatf("rand i%0d n%0d", i, n), 16'(obs(i)), 16'(exp));
            m_ready = !m_act || m_t >= 4 * h + 1;
            din_valid[i] = ($urandom_range(0, 3) != 0);
            din[i] = 8'($urandom);
            acc = din_valid[i] && m_ready;
            @(posedge clk);
            if (acc) begin
                m_word = din[i];
                m_act = 1;
                m_t = 1;
            end else if (m_act && m_t < 1000) begin
                m_t++;
            end
        end
        @(negedge clk);
        din_valid[i] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0] syms [4];
        rst_n = 4'b0000;
        din_valid = 4'b0000;
        for (int i = 0; i < 4; i++) din[i] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++)
            check($sformatf("reset i%0d", i), 16'(obs(i)), 16'({idle_of(i), 4'b0000}));
        rst_n = 4'b1111;

        // H=1, 8'b10_01_11_00
        tab_n = 0;
        set_row(1, 2'b10, 1, 0, 0, 1);
        set_row(2, 2'b01, 1, 0, 0, 1);
        set_row(3, 2'b11, 1, 0, 0, 1);
        set_row(4, 2'b00, 1, 0, 0, 1);
        set_row(5, 2'b00, 0, 1, 1, 0);
        set_row(6, 2'b00, 0, 0, 1, 0);
        apply(0, "h1_word", 8'b10_01_11_00, 8'h00, 1'b0, -5);

        // H=3, 8'hB4 -> 10,11,01,00
        tab_n = 0;
        syms = '{2'b10, 2'b11, 2'b01, 2'b00};
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 3; j++)
                set_row(1 + k * 3 + j, syms[k], 1, 0, 0, 1);
        set_row(13, 2'b00, 0, 1, 1, 0);
        set_row(14, 2'b00, 0, 0, 1, 0);
        apply(1, "h3_b4", 8'hB4, 8'h00, 1'b0, -5);

        // H=1 back-to-back FF then 00
        tab_n = 0;
        for (int c = 1; c <= 4; c++) set_row(c, 2'b11, 1, 0, 0, 1);
        set_row(5, 2'b00, 0, 1, 1, 0);
        for (int c = 6; c <= 9; c++) set_row(c, 2'b00, 1, 0, 0, 1);
        set_row(10, 2'b00, 0, 1, 1, 0);
        set_row(11, 2'b00, 0, 0, 1, 0);
        apply(0, "b2b", 8'hFF, 8'h00, 1'b1, -5);

        // H=2, 8'hAA with a 8'h55 pulse during SEND
        tab_n = 0;
        for (int c = 1; c <= 8; c++) set_row(c, 2'b10, 1, 0, 0, 1);
        set_row(9, 2'b00, 0, 1, 1, 0);
        set_row(10, 2'b00, 0, 0, 1, 0);
        set_row(11, 2'b00, 0, 0, 1, 0);
        apply(2, "ignore_55", 8'hAA, 8'h00, 1'b0, 3);

        // H=2, reset during cycle 3 of a word
        @(negedge clk);
        din[2] = 8'hC3;
        din_valid[2] = 1'b1;
        @(posedge clk);
        #1;
        din_valid[2] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n[2] = 1'b0;
        #1;
        check("rst_mid ready_low", 16'(din_ready[2]), 16'd0);
        check("rst_mid busy_low", 16'(busy[2]), 16'd0);
        for (int c = 4; c <= 5; c++) begin
            @(negedge clk);
            check($sformatf("rst_mid c%0d", c), 16'(obs(2)), 16'b000000);
        end
        rst_n[2] = 1'b1;
        for (int c = 6; c <= 10; c++) begin
            @(negedge clk);
            check($sformatf("rst_after c%0d", c), 16'(obs(2)), 16'b000010);
        end

        // IDLE_SYM=11 instance idles after reset
        pulse_reset(3);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("idle11 c%0d", c), 16'({x1[3], x2[3], sym_valid[3]}), 16'b110);
        end

        run_random(0, 250);
        run_random(1, 300);
        run_random(2, 300);
        run_random(3, 150);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
